// File: rtl/l2_lookup_driver_if.sv
// Address-source and cache-lookup signals seen by the L2 lookup driver.
// master = the driver, slave = the environment (address source plus cache).
interface l2_lookup_driver_if #(
    parameter int way             = 16,
    parameter int block_size_byte = 16,
    parameter int set_size        = 64
);
    localparam int bo_w  = $clog2(block_size_byte);
    localparam int si_w  = $clog2(set_size);
    localparam int ww    = $clog2(way);
    localparam int tag_w = 32 - si_w - bo_w;

    logic              addr_valid;
    logic [31:0]       addr_in;
    logic              addr_ready;
    logic [tag_w-1:0]  tag;
    logic [si_w-1:0]   index;
    logic [bo_w-1:0]   block_offset;
    logic              find_start;
    logic              found_in_cache;
    logic [ww:0]       hit_way;
    logic              done;
    logic              updated;

    modport master (
        input  addr_valid, addr_in, found_in_cache, hit_way, done, updated,
        output addr_ready, tag, index, block_offset, find_start
    );

    modport slave (
        output addr_valid, addr_in, found_in_cache, hit_way, done, updated,
        input  addr_ready, tag, index, block_offset, find_start
    );
endinterface

// File: rtl/l2_lookup_driver.sv
// Initiator side of the L2 lookup handshake: buffers trace addresses, issues one
// lookup at a time, waits for the cache update pulse and keeps hit/miss statistics.
module l2_lookup_driver #(
    parameter int way             = 16,
    parameter int block_size_byte = 16,
    parameter int set_size        = 64,
    parameter int fifo_depth      = 4,
    parameter int timeout_cycles  = 64
) (
    input  logic                   clk,
    input  logic                   reset,
    l2_lookup_driver_if.master     bus,
    output logic                   result_valid,
    output logic                   result_hit,
    output logic [$clog2(way):0]   result_way,
    output logic [19:0]            access_count,
    output logic [19:0]            hit_count,
    output logic [19:0]            miss_count,
    output logic                   timeout_err,
    output logic                   busy
);
    localparam int bo_w  = $clog2(block_size_byte);
    localparam int si_w  = $clog2(set_size);
    localparam int tag_w = 32 - si_w - bo_w;
    localparam int ptr_w = $clog2(fifo_depth);
    localparam int cnt_w = ptr_w + 1;
    localparam int tmr_w = $clog2(timeout_cycles) + 1;
    localparam logic [cnt_w-1:0] cnt_full = cnt_w'(fifo_depth);
    localparam logic [tmr_w-1:0] tmr_last = tmr_w'(timeout_cycles - 1);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RELEASE} state_t;

    function automatic logic [19:0] sat_inc(input logic [19:0] v);
        return (v == 20'hFFFFF) ? v : v + 20'd1;
    endfunction

    state_t             state, state_next;
    logic [31:0]        mem [fifo_depth];
    logic [ptr_w-1:0]   wr_ptr, rd_ptr;
    logic [cnt_w-1:0]   count, count_next;
    logic               addr_ready_q;
    logic [31:0]        addr_q;
    logic [tmr_w-1:0]   timer;
    logic [tmr_w-1:0]   timer_inc;
    logic               push, pop, issue, complete, expire;
    logic               done_unused;

    // Completion is taken from updated alone; a stale done is meaningless here.
    assign done_unused = bus.done;

    assign push      = bus.addr_valid & addr_ready_q;
    assign timer_inc = timer + tmr_w'(1);

    always_comb begin
        count_next = count;
        case ({push, pop})
            2'b10:   count_next = count + cnt_w'(1);
            2'b01:   count_next = count - cnt_w'(1);
            default: count_next = count;
        endcase
    end

    always_comb begin
        state_next = state;
        pop        = 1'b0;
        issue      = 1'b0;
        complete   = 1'b0;
        expire     = 1'b0;
        case (state)
            S_IDLE: begin
                if (count != '0) begin
                    pop        = 1'b1;
                    state_next = S_ISSUE;
                end
            end
            S_ISSUE: begin
                issue      = 1'b1;
                state_next = S_WAIT;
            end
            S_WAIT: begin
                if (bus.updated) begin
                    complete   = 1'b1;
                    state_next = S_RELEASE;
                end else if (timer_inc == tmr_last) begin
                    // Fires on the edge that lands timeout_cycles after find_start rose.
                    expire     = 1'b1;
                    state_next = S_RELEASE;
                end
            end
            S_RELEASE: state_next = S_IDLE;
            default:   state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= bus.addr_in;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= S_IDLE;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            addr_ready_q <= 1'b0;
            addr_q       <= '0;
            timer        <= '0;
        end else begin
            state        <= state_next;
            count        <= count_next;
            addr_ready_q <= (count_next != cnt_full);
            if (push) wr_ptr <= wr_ptr + ptr_w'(1);
            if (pop) begin
                rd_ptr <= rd_ptr + ptr_w'(1);
                addr_q <= mem[rd_ptr];
            end
            if (issue)                timer <= '0;
            else if (state == S_WAIT) timer <= timer_inc;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            result_valid <= 1'b0;
            result_hit   <= 1'b0;
            result_way   <= '0;
            access_count <= '0;
            hit_count    <= '0;
            miss_count   <= '0;
            timeout_err  <= 1'b0;
        end else begin
            result_valid <= complete;
            if (complete) begin
                result_hit <= bus.found_in_cache;
                result_way <= bus.hit_way;
                if (bus.found_in_cache) hit_count  <= sat_inc(hit_count);
                else                    miss_count <= sat_inc(miss_count);
            end
            if (complete || expire) access_count <= sat_inc(access_count);
            if (expire)             timeout_err  <= 1'b1;
        end
    end

    assign bus.addr_ready   = addr_ready_q;
    assign bus.find_start   = issue;
    assign bus.tag          = addr_q[31 -: tag_w];
    assign bus.index        = addr_q[bo_w +: si_w];
    assign bus.block_offset = addr_q[bo_w-1:0];
    assign busy             = (count != '0) || (state != S_IDLE);
endmodule

// File: tb/tb_l2_lookup_driver.sv
// Bench for l2_lookup_driver: table of lookups against a scripted cache model,
// plus sequences for back-pressure, timeout, mid-lookup reset and a deep-way hit.
module tb_l2_lookup_driver;
    localparam int lat = 1;

    typedef struct {
        logic [31:0] addr;
        logic [21:0] tag;
        logic [5:0]  idx;
        logic [3:0]  bo;
        logic        hit;
        logic [4:0]  way;
        bit          noupd;
    } vec_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    l2_lookup_driver_if bus ();
    logic        result_valid, result_hit, timeout_err, busy;
    logic [4:0]  result_way;
    logic [19:0] access_count, hit_count, miss_count;

    l2_lookup_driver dut (
        .clk          (clk),
        .reset        (reset),
        .bus          (bus),
        .result_valid (result_valid),
        .result_hit   (result_hit),
        .result_way   (result_way),
        .access_count (access_count),
        .hit_count    (hit_count),
        .miss_count   (miss_count),
        .timeout_err  (timeout_err),
        .busy         (busy)
    );

    int     n_checks = 0;
    int     n_fail = 0;
    longint cyc = 0;
    vec_t   exp_q[$];
    vec_t   res_q[$];
    int     n_results = 0;
    int     acc_exp = 0, hit_exp = 0, miss_exp = 0;
    bit     hold = 0;
    int     n_accepted = 0;
    longint last_fs = -1;
    vec_t   tbl[6];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic flag_fail(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s actual=event required=no_event", name);
    endtask

    task automatic check_reset_outputs(input string ctx);
        check({ctx, "_addr_ready"}, bus.addr_ready, 0);
        check({ctx, "_find_start"}, bus.find_start, 0);
        check({ctx, "_tag"}, bus.tag, 0);
        check({ctx, "_index"}, bus.index, 0);
        check({ctx, "_block_offset"}, bus.block_offset, 0);
        check({ctx, "_result_valid"}, result_valid, 0);
        check({ctx, "_result_hit"}, result_hit, 0);
        check({ctx, "_result_way"}, result_way, 0);
        check({ctx, "_access_count"}, access_count, 0);
        check({ctx, "_hit_count"}, hit_count, 0);
        check({ctx, "_miss_count"}, miss_count, 0);
        check({ctx, "_timeout_err"}, timeout_err, 0);
        check({ctx, "_busy"}, busy, 0);
    endtask

    // Called on a falling edge; returns on the falling edge after acceptance.
    task automatic push_vec(input vec_t v);
        int g = 0;
        bus.addr_valid = 1'b1;
        bus.addr_in    = v.addr;
        while (!bus.addr_ready && g < 300) begin
            @(negedge clk);
            g++;
        end
        check("push_accept", bus.addr_ready, 1);
        if (bus.addr_ready) begin
            exp_q.push_back(v);
            n_accepted++;
        end
        @(negedge clk);
        bus.addr_valid = 1'b0;
    endtask

    task automatic wait_results(input int n);
        int g = 0;
        while (n_results < n && g < 600) begin
            @(negedge clk);
            g++;
        end
        check("result_count", n_results, n);
    endtask

    // Cache model: answers each find_start with the scripted response after
    // lat (+ way on a hit) cycles, leaving done high afterwards as a stale flag.
    initial begin : cache_model
        int   cnt;
        bit   pend;
        vec_t e;
        bus.updated        = 1'b0;
        bus.done           = 1'b0;
        bus.found_in_cache = 1'b0;
        bus.hit_way        = '0;
        pend = 0;
        cnt  = 0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                pend        = 0;
                bus.updated = 1'b0;
            end else begin
                if (bus.updated) bus.updated = 1'b0;
                if (pend && !hold) begin
                    if (cnt == 0) begin
                        bus.updated        = 1'b1;
                        bus.done           = 1'b1;
                        bus.found_in_cache = e.hit;
                        bus.hit_way        = e.way;
                        pend = 0;
                    end else begin
                        cnt--;
                    end
                end
                if (bus.find_start) begin
                    if (last_fs >= 0) check("find_start_gap", (cyc - last_fs) >= 4 + lat, 1);
                    last_fs = cyc;
                    if (exp_q.size() == 0) begin
                        flag_fail("find_start_unexpected");
                    end else begin
                        e = exp_q.pop_front();
                        check("tag", bus.tag, e.tag);
                        check("index", bus.index, e.idx);
                        check("block_offset", bus.block_offset, e.bo);
                        if (!e.noupd) begin
                            pend = 1;
                            cnt  = lat + (e.hit ? int'(e.way) : 0);
                            res_q.push_back(e);
                        end
                    end
                end
            end
        end
    end

    initial begin : result_monitor
        vec_t r;
        forever begin
            @(negedge clk);
            if (reset && result_valid) begin
                if (res_q.size() == 0) begin
                    flag_fail("result_valid_spurious");
                end else begin
                    r = res_q.pop_front();
                    check("result_hit", result_hit, r.hit);
                    check("result_way", result_way, r.way);
                    acc_exp++;
                    if (r.hit) hit_exp++;
                    else       miss_exp++;
                    check("access_count", access_count, acc_exp);
                    check("hit_count", hit_count, hit_exp);
                    check("miss_count", miss_count, miss_exp);
                end
                n_results++;
            end
        end
    end

    initial begin : main
        vec_t v;
        int   base;
        tbl[0] = '{32'h0000_1234, 22'h000004, 6'h23, 4'h4, 1'b0, 5'd16, 1'b0};
        tbl[1] = '{32'h0000_1234, 22'h000004, 6'h23, 4'h4, 1'b1, 5'd0,  1'b0};
        tbl[2] = '{32'hFFFF_FFFF, 22'h3FFFFF, 6'h3F, 4'hF, 1'b1, 5'd15, 1'b0};
        tbl[3] = '{32'h0000_0000, 22'h000000, 6'h00, 4'h0, 1'b0, 5'd16, 1'b0};
        tbl[4] = '{32'hABCD_EF01, 22'h2AF37B, 6'h30, 4'h1, 1'b1, 5'd3,  1'b0};
        tbl[5] = '{32'h1234_5678, 22'h048D15, 6'h27, 4'h8, 1'b1, 5'd7,  1'b0};
        bus.addr_valid = 1'b0;
        bus.addr_in    = '0;

        #2 reset = 1'b0;
        #1 check_reset_outputs("reset");
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1 check("ready_before_clock", bus.addr_ready, 0);
        @(negedge clk);
        check("ready_after_release", bus.addr_ready, 1);

        for (int i = 0; i < 6; i++) begin
            push_vec(tbl[i]);
            wait_results(i + 1);
        end
        repeat (3) @(negedge clk);
        check("idle_after_table", busy, 0);

        // Back-pressure with a stalled cache: one entry in flight plus a full FIFO.
        hold = 1;
        n_accepted = 0;
        base = n_results;
        fork
            begin
                for (int i = 0; i < 6; i++) begin
                    v = '{32'h0000_2000 + 32'(i * 16), 22'h8, 6'(i), 4'h0, 1'b1, 5'(i + 1), 1'b0};
                    push_vec(v);
                end
            end
            begin
                int g = 0;
                while (bus.addr_ready && g < 100) begin
                    @(negedge clk);
                    g++;
                end
                check("ready_drop", bus.addr_ready, 0);
                check("accepted_before_full", n_accepted, 5);
                check("busy_when_full", busy, 1);
                repeat (5) @(negedge clk);
                hold = 0;
            end
        join
        wait_results(base + 6);

        // Cache never answers the first lookup; the next queued lookup still runs.
        base = n_results;
        push_vec('{32'h0000_4440, 22'h11, 6'h04, 4'h0, 1'b0, 5'd16, 1'b1});
        push_vec('{32'h0000_0010, 22'h00, 6'h01, 4'h0, 1'b0, 5'd16, 1'b0});
        begin
            int g = 0;
            while (!timeout_err && g < 300) begin
                @(negedge clk);
                g++;
            end
        end
        check("timeout_err_set", timeout_err, 1);
        check("timeout_latency", cyc - last_fs, 64);
        check("timeout_no_result", result_valid, 0);
        acc_exp++;
        check("timeout_access_count", access_count, acc_exp);
        wait_results(base + 1);
        check("timeout_sticky", timeout_err, 1);

        // Asynchronous reset while a lookup is waiting on the cache.
        hold = 1;
        push_vec('{32'h0000_3000, 22'h0C, 6'h00, 4'h0, 1'b1, 5'd2, 1'b0});
        repeat (6) @(negedge clk);
        check("wait_busy", busy, 1);
        check("wait_tag", bus.tag, 22'h0C);
        #2 reset = 1'b0;
        #1 check_reset_outputs("midreset");
        hold = 0;
        exp_q.delete();
        res_q.delete();
        acc_exp = 0;
        hit_exp = 0;
        miss_exp = 0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        base = n_results;
        push_vec(tbl[0]);
        wait_results(base + 1);

        // Hit in way 9: nine extra update cycles, still a single result.
        base = n_results;
        push_vec('{32'h0000_5678, 22'h15, 6'h27, 4'h8, 1'b1, 5'd9, 1'b0});
        wait_results(base + 1);
        repeat (20) @(negedge clk);
        check("way9_single_result", n_results, base + 1);
        check("way9_no_timeout", timeout_err, 0);
        check("final_idle", busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
